dpram_be: RTL and testbench
===========================

// Module: dpram_be
// PURPOSE
// - Parametrised true dual-port RAM, one clock. Successor to the plain dpram.
// - Adds per-byte write enables, a selectable read latency (1 or 2) and a clear-on-reset sweep FSM.
// - Chip selects are pipelined in step with read data.
// - Used for video/line buffers and CPU-shared RAMs that must start from a known state.
// PARAMETERS
// - addr_width      8     word address bits; depth = 2**addr_width
// - data_width      16    word width; must be a multiple of 8
// - read_latency    1     clocks from address sample to q; legal values 1 or 2
// - clear_on_reset  1     1: sweep all words to clear_value after reset; 0: no sweep
// - clear_value     '0    word written by the sweep (data_width bits)
// - disable_value   1'b1  bit replicated on q while deselected or busy
// PORTS
// - clock       in   1            sole clock, rising edge
// - reset       in   1            synchronous, active-high
// - busy        out  1            clear sweep in progress
// - address_a   in   addr_width   port A word address
// - data_a      in   data_width   port A write data
// - byteena_a   in   data_width/8 port A byte write enables; bit i covers byte i
// - enable_a    in   1            port A clock enable; low = port A frozen
// - wren_a      in   1            port A write request
// - cs_a        in   1            port A chip select
// - q_a         out  data_width   port A read data
// - *_b         -    -            port B ports, identical to port A
// - collision   out  1            present only with DPRAM_COLLISION_EN
// BEHAVIOUR
// - Reset and ready state:
//   - While reset is high: busy = clear_on_reset; q_a and q_b = {data_width{disable_value}}; collision = 0.
//   - Read pipelines flush.
// - FSM (dpram_state_e):
//   - ST_CLEAR: internal counter walks addresses 0 .. 2**addr_width-1.
//     - One full-word write of clear_value per clock; busy = 1.
//     - All user writes are dropped; q shows the disable pattern.
//   - ST_CLEAR -> ST_READY in the clock after address 2**addr_width-1 is written; busy falls on that edge.
//   - Reset asserted mid-sweep: the counter restarts at 0.
//   - clear_on_reset = 0: reset goes straight to ST_READY.
// - Write: when ST_READY, enable_x, wren_x and cs_x are all high, each byte with byteena_x[i] = 1 is written at the edge.
// - Read: address sampled at an edge with enable_x = 1; data appears after read_latency edges.
//   - cs_x is sampled with the address and delayed alongside the data.
//   - q_x = disable pattern if the delayed cs was 0.
//   - enable_x = 0 holds every pipeline stage of that port.
// - Same-port read-during-write: q returns a merged word (new bytes where enabled, old bytes elsewhere).
// - Cross-port read of an address written in the same cycle: returns old data.
// - Both ports write the same address in the same cycle: port A wins per byte.
//   - Bytes enabled only on B take B's data.
// - read_latency = 2 adds an output register; q updates one edge later than with read_latency = 1.
// CONFIGURATION
// - DPRAM_COLLISION_EN defined:
//   - collision is a registered pulse, high for one clock, in the cycle after both ports write the same address with overlapping byteena.
//   - Reset value 0.
// - DPRAM_COLLISION_EN undefined: no collision port and no compare logic; write behaviour is unchanged.
// STRUCTURE
// - Package dpram_pkg:
//   - typedef enum logic {ST_CLEAR, ST_READY} dpram_state_e
//   - localparam BYTE_W = 8
//   - function nbytes(data_width)
// - Sub-module dpram_rdpipe: per-port read pipeline.
//   - Contents: cs delay, optional second stage, disable-value gating.
//   - Instantiated twice.
// - Storage: behavioural byte-lane array so synthesis infers block RAM with byte enables.
// TESTING
// - Reset sweep: addr_width = 4, clear_on_reset = 1, reset 1 clock.
//   - Expect busy high for 16 clocks, then low.
//   - Every address reads 0x0000.
//   - A write issued during busy is not stored.
// - Reset mid-sweep: assert reset at sweep address 7.
//   - Expect busy to stay high 16 clocks from the new reset release; the counter restarts at 0.
// - Byte enables: write 0xABCD with byteena_a = 2'b01 over 0x1234.
//   - Port B read returns 0x12CD after read_latency clocks.
// - Latency/cs: read_latency = 2, cs_b low on the read cycle.
//   - q_b = 0xFFFF exactly 2 clocks later; the next read with cs_b high returns data.
// - Collision: both ports write address 5 (A = 0x1111, B = 0x2222, full byteena).
//   - Memory holds 0x1111.
//   - With DPRAM_COLLISION_EN, collision pulses once on the next clock.
// - Read-during-write: port A writes 0x00EE with byteena 2'b01 to a word holding 0x5500.
//   - q_a shows 0x55EE; same-cycle q_b shows 0x5500.

Source files
------------

// File: rtl/dpram_pkg.sv
// Shared types and helpers for the byte-enable dual-port RAM.
package dpram_pkg;

    typedef enum logic {ST_CLEAR, ST_READY} dpram_state_e;

    localparam int unsigned BYTE_W = 8;

    function automatic int unsigned nbytes(input int unsigned data_width);
        return data_width / BYTE_W;
    endfunction

endpackage

// File: rtl/dpram_rdpipe.sv
// Per-port read pipeline: data and chip select advance together, one or two stages,
// with the disable pattern substituted when deselected or gated.
module dpram_rdpipe
    import dpram_pkg::*;
#(
    parameter int unsigned data_width    = 16,
    parameter int unsigned read_latency  = 1,
    parameter logic        disable_value = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en_i,
    input  logic                  cs_i,
    input  logic                  gate_i,
    input  logic [data_width-1:0] rdata_i,
    output logic [data_width-1:0] q_o
);

    logic                  cs1_q, cs1_d;
    logic [data_width-1:0] data1_q, data1_d;
    logic                  cs_out;
    logic [data_width-1:0] data_out;

    always_comb begin
        cs1_d   = cs1_q;
        data1_d = data1_q;
        if (en_i) begin
            cs1_d   = cs_i;
            data1_d = rdata_i;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cs1_q <= 1'b0;
        end else begin
            cs1_q <= cs1_d;
        end
    end

    always_ff @(posedge clock) begin
        data1_q <= data1_d;
    end

    if (read_latency == 2) begin : g_stage2
        logic                  cs2_q, cs2_d;
        logic [data_width-1:0] data2_q, data2_d;

        always_comb begin
            cs2_d   = cs2_q;
            data2_d = data2_q;
            if (en_i) begin
                cs2_d   = cs1_q;
                data2_d = data1_q;
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                cs2_q <= 1'b0;
            end else begin
                cs2_q <= cs2_d;
            end
        end

        always_ff @(posedge clock) begin
            data2_q <= data2_d;
        end

        assign cs_out   = cs2_q;
        assign data_out = data2_q;
    end else begin : g_stage1
        assign cs_out   = cs1_q;
        assign data_out = data1_q;
    end

    always_comb begin
        q_o = data_out;
        if (gate_i || !cs_out) begin
            q_o = {data_width{disable_value}};
        end
    end

endmodule

// File: rtl/dpram_be.sv
// True dual-port RAM with byte enables, 1/2-cycle read latency and a clear-on-reset sweep.
// Optional collision flag enabled by defining DPRAM_COLLISION_EN.
module dpram_be
    import dpram_pkg::*;
#(
    parameter int unsigned           addr_width     = 8,
    parameter int unsigned           data_width     = 16,
    parameter int unsigned           read_latency   = 1,
    parameter int unsigned           clear_on_reset = 1,
    parameter logic [data_width-1:0] clear_value    = '0,
    parameter logic                  disable_value  = 1'b1
) (
    input  logic                             clock,
    input  logic                             reset,
    output logic                             busy,
`ifdef DPRAM_COLLISION_EN
    output logic                             collision,
`endif
    input  logic [addr_width-1:0]            address_a,
    input  logic [data_width-1:0]            data_a,
    input  logic [nbytes(data_width)-1:0]    byteena_a,
    input  logic                             enable_a,
    input  logic                             wren_a,
    input  logic                             cs_a,
    output logic [data_width-1:0]            q_a,
    input  logic [addr_width-1:0]            address_b,
    input  logic [data_width-1:0]            data_b,
    input  logic [nbytes(data_width)-1:0]    byteena_b,
    input  logic                             enable_b,
    input  logic                             wren_b,
    input  logic                             cs_b,
    output logic [data_width-1:0]            q_b
);

    localparam int unsigned NB    = nbytes(data_width);
    localparam int unsigned DEPTH = 2 ** addr_width;
    localparam logic [addr_width-1:0] ADDR_ONE = 1;
    localparam dpram_state_e RESET_STATE = (clear_on_reset != 0) ? ST_CLEAR : ST_READY;

    logic [NB-1:0][BYTE_W-1:0] mem [DEPTH];

    dpram_state_e          state_q, state_d;
    logic [addr_width-1:0] clr_addr_q, clr_addr_d;
    logic                  ready, sweep_we, gate;
    logic [NB-1:0]         be_wr_a, be_wr_b;
    logic [data_width-1:0] rdata_a, rdata_b;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (state_q == ST_CLEAR) begin
            clr_addr_d = clr_addr_q + ADDR_ONE;
            if (&clr_addr_q) begin
                state_d = ST_READY;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= RESET_STATE;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        ready    = (state_q == ST_READY) && !reset;
        sweep_we = (state_q == ST_CLEAR) && !reset;
        busy     = reset ? (clear_on_reset != 0) : (state_q == ST_CLEAR);
        gate     = busy || reset;
        be_wr_a  = {NB{ready && enable_a && wren_a && cs_a}} & byteena_a;
        be_wr_b  = {NB{ready && enable_b && wren_b && cs_b}} & byteena_b;
    end

    // Same-port read returns the word as it will be after this edge's write;
    // the other port's write is not visible until the next read.
    always_comb begin
        rdata_a = mem[address_a];
        rdata_b = mem[address_b];
        for (int i = 0; i < NB; i++) begin
            if (be_wr_a[i]) rdata_a[i*BYTE_W +: BYTE_W] = data_a[i*BYTE_W +: BYTE_W];
            if (be_wr_b[i]) rdata_b[i*BYTE_W +: BYTE_W] = data_b[i*BYTE_W +: BYTE_W];
        end
    end

    // Port A lanes are written last so A wins any byte both ports enable.
    always_ff @(posedge clock) begin
        if (sweep_we) begin
            mem[clr_addr_q] <= clear_value;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (be_wr_b[i]) mem[address_b][i] <= data_b[i*BYTE_W +: BYTE_W];
            end
            for (int i = 0; i < NB; i++) begin
                if (be_wr_a[i]) mem[address_a][i] <= data_a[i*BYTE_W +: BYTE_W];
            end
        end
    end

`ifdef DPRAM_COLLISION_EN
    logic collision_q, collision_d;

    always_comb begin
        collision_d = (address_a == address_b) && (|(be_wr_a & be_wr_b));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            collision_q <= 1'b0;
        end else begin
            collision_q <= collision_d;
        end
    end

    assign collision = collision_q && !reset;
`endif

    dpram_rdpipe #(
        .data_width   (data_width),
        .read_latency (read_latency),
        .disable_value(disable_value)
    ) u_rdpipe_a (
        .clock  (clock),
        .reset  (reset),
        .en_i   (enable_a),
        .cs_i   (cs_a),
        .gate_i (gate),
        .rdata_i(rdata_a),
        .q_o    (q_a)
    );

    dpram_rdpipe #(
        .data_width   (data_width),
        .read_latency (read_latency),
        .disable_value(disable_value)
    ) u_rdpipe_b (
        .clock  (clock),
        .reset  (reset),
        .en_i   (enable_b),
        .cs_i   (cs_b),
        .gate_i (gate),
        .rdata_i(rdata_b),
        .q_o    (q_b)
    );

endmodule

// File: tb/tb_dpram_be.sv
// Directed bench: two instances (read latency 1 and 2) share one stimulus stream.
module tb_dpram_be;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  addr_a, addr_b;
    logic [15:0] din_a, din_b;
    logic [1:0]  be_a, be_b;
    logic        en_a, en_b, we_a, we_b, cs_a, cs_b;
    logic [15:0] q_a1, q_b1, q_a2, q_b2;
    logic        busy1, busy2;
`ifdef DPRAM_COLLISION_EN
    logic        coll1, coll2;
`endif

    int tests = 0;
    int fails = 0;
    int n;

    always #5 clock = ~clock;

    dpram_be #(
        .addr_width(4), .data_width(16), .read_latency(1),
        .clear_on_reset(1), .clear_value(16'h0000), .disable_value(1'b1)
    ) u_dut1 (
        .clock(clock), .reset(reset), .busy(busy1),
`ifdef DPRAM_COLLISION_EN
        .collision(coll1),
`endif
        .address_a(addr_a), .data_a(din_a), .byteena_a(be_a), .enable_a(en_a),
        .wren_a(we_a), .cs_a(cs_a), .q_a(q_a1),
        .address_b(addr_b), .data_b(din_b), .byteena_b(be_b), .enable_b(en_b),
        .wren_b(we_b), .cs_b(cs_b), .q_b(q_b1)
    );

    dpram_be #(
        .addr_width(4), .data_width(16), .read_latency(2),
        .clear_on_reset(1), .clear_value(16'h0000), .disable_value(1'b1)
    ) u_dut2 (
        .clock(clock), .reset(reset), .busy(busy2),
`ifdef DPRAM_COLLISION_EN
        .collision(coll2),
`endif
        .address_a(addr_a), .data_a(din_a), .byteena_a(be_a), .enable_a(en_a),
        .wren_a(we_a), .cs_a(cs_a), .q_a(q_a2),
        .address_b(addr_b), .data_b(din_b), .byteena_b(be_b), .enable_b(en_b),
        .wren_b(we_b), .cs_b(cs_b), .q_b(q_b2)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr_a(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
        addr_a = a; din_a = d; be_a = be; we_a = 1'b1; cs_a = 1'b1;
        tick();
        we_a = 1'b0; cs_a = 1'b0; be_a = 2'b11;
    endtask

    task automatic rd_a(input logic [3:0] a, input logic [15:0] exp);
        addr_a = a; cs_a = 1'b1;
        tick();
        chk("rd_a_lat1", q_a1, exp);
        tick();
        chk("rd_a_lat2", q_a2, exp);
        cs_a = 1'b0;
    endtask

    task automatic rd_b(input logic [3:0] a, input logic [15:0] exp);
        addr_b = a; cs_b = 1'b1;
        tick();
        chk("rd_b_lat1", q_b1, exp);
        tick();
        chk("rd_b_lat2", q_b2, exp);
        cs_b = 1'b0;
    endtask

    task automatic wr_ab(input logic [3:0] a, input logic [15:0] da, input logic [1:0] ba,
                         input logic [15:0] db, input logic [1:0] bb);
        addr_a = a; din_a = da; be_a = ba; we_a = 1'b1; cs_a = 1'b1;
        addr_b = a; din_b = db; be_b = bb; we_b = 1'b1; cs_b = 1'b1;
        tick();
        we_a = 1'b0; cs_a = 1'b0; we_b = 1'b0; cs_b = 1'b0;
        be_a = 2'b11; be_b = 2'b11;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        addr_a = '0; addr_b = '0; din_a = '0; din_b = '0;
        be_a = 2'b11; be_b = 2'b11;
        en_a = 1'b1; en_b = 1'b1; we_a = 1'b0; we_b = 1'b0; cs_a = 1'b0; cs_b = 1'b0;

        // Reset state
        tick();
        chk("reset_busy", {15'b0, busy1}, 16'h0001);
        chk("reset_q_a1", q_a1, 16'hFFFF);
        chk("reset_q_b2", q_b2, 16'hFFFF);
        reset = 1'b0;

        // Walk the sweep to address 7, then restart it with a fresh reset
        for (int i = 0; i < 7; i++) begin
            chk("sweep_busy", {15'b0, busy1}, 16'h0001);
            tick();
        end
        reset = 1'b1;
        tick();
        chk("midreset_busy", {15'b0, busy2}, 16'h0001);
        reset = 1'b0;

        n = 0;
        while (busy1 && n < 40) begin
            n++;
            if (n == 5) begin
                addr_a = 4'd3; din_a = 16'h5A5A; be_a = 2'b11; we_a = 1'b1; cs_a = 1'b1;
            end
            if (n == 6) begin
                chk("q_a_busy", q_a1, 16'hFFFF);
                we_a = 1'b0; cs_a = 1'b0;
            end
            tick();
        end
        chk("busy_cycles", 16'(n), 16'd16);
        chk("busy2_low", {15'b0, busy2}, 16'h0000);

        // Every word cleared; the write during busy at address 3 was dropped
        for (int a = 0; a < 16; a++) begin
            rd_a(4'(a), 16'h0000);
        end

        // Byte enables
        wr_a(4'd2, 16'h1234, 2'b11);
        wr_a(4'd2, 16'hABCD, 2'b01);
        rd_b(4'd2, 16'h12CD);

        // Delayed chip select
        wr_a(4'd4, 16'hBEEF, 2'b11);
        addr_b = 4'd4; cs_b = 1'b0;
        tick();
        chk("cs_low_lat1", q_b1, 16'hFFFF);
        cs_b = 1'b1;
        tick();
        chk("cs_low_lat2", q_b2, 16'hFFFF);
        chk("cs_high_lat1", q_b1, 16'hBEEF);
        tick();
        chk("cs_high_lat2", q_b2, 16'hBEEF);

        // enable low freezes the pipeline
        en_b = 1'b0; addr_b = 4'd2; cs_b = 1'b0;
        tick();
        tick();
        chk("hold_lat1", q_b1, 16'hBEEF);
        chk("hold_lat2", q_b2, 16'hBEEF);
        en_b = 1'b1;
        tick();
        chk("unhold_lat1", q_b1, 16'hFFFF);
        tick();
        chk("unhold_lat2", q_b2, 16'hFFFF);

        // Collisions: A wins overlapping bytes, B keeps bytes only it enables
        wr_ab(4'd5, 16'h1111, 2'b11, 16'h2222, 2'b11);
`ifdef DPRAM_COLLISION_EN
        chk("coll_pulse1", {15'b0, coll1}, 16'h0001);
        chk("coll_pulse2", {15'b0, coll2}, 16'h0001);
        tick();
        chk("coll_clear", {15'b0, coll1}, 16'h0000);
`endif
        rd_b(4'd5, 16'h1111);
        wr_ab(4'd6, 16'h0033, 2'b01, 16'h4444, 2'b11);
        rd_a(4'd6, 16'h4433);
        wr_ab(4'd7, 16'h00AA, 2'b01, 16'hBB00, 2'b10);
`ifdef DPRAM_COLLISION_EN
        chk("coll_disjoint", {15'b0, coll1}, 16'h0000);
`endif
        rd_b(4'd7, 16'hBBAA);

        // Read during write: same port sees merged word, other port sees old word
        wr_a(4'd8, 16'h5500, 2'b11);
        addr_a = 4'd8; din_a = 16'h00EE; be_a = 2'b01; we_a = 1'b1; cs_a = 1'b1;
        addr_b = 4'd8; cs_b = 1'b1;
        tick();
        chk("rdw_q_a1", q_a1, 16'h55EE);
        chk("rdw_q_b1", q_b1, 16'h5500);
        we_a = 1'b0; be_a = 2'b11;
        tick();
        chk("rdw_q_a2", q_a2, 16'h55EE);
        chk("rdw_q_b2", q_b2, 16'h5500);
        cs_a = 1'b0; cs_b = 1'b0;
        rd_b(4'd8, 16'h55EE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
